// File: rtl/qpp_ind_gen.sv
// qpp_ind_gen: QPP interleaver index generator; define QPP_ADDR_EN to enable the interleaved-address datapath
module qpp_ind_gen #(
  parameter int IDX_W = 14,
  parameter int K_S = 1056,
  parameter int K_L = 6144,
  parameter int F1_S = 17,
  parameter int F2_S = 66,
  parameter int F1_L = 263,
  parameter int F2_L = 480
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             k,
  input  logic             ready,
  input  logic             hold,
  output logic [IDX_W-1:0] out,
  output logic [IDX_W-1:0] out_int,
  output logic             valid,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE1, DONE2} state_t;
  localparam logic [IDX_W-1:0] LAST_S = IDX_W'(K_S - 1);
  localparam logic [IDX_W-1:0] LAST_L = IDX_W'(K_L - 1);
  state_t state;
  logic   k_sel;
  logic   last;
  assign last = out == (k_sel ? LAST_L : LAST_S);
  // Block sequencing: start latch, index counter, valid and the two-cycle done flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k_sel <= 1'b0;
      out   <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ready) begin
          state <= RUN;
          k_sel <= k;
          out   <= '0;
          valid <= 1'b1;
        end
        RUN: if (!hold) begin
          if (last) begin
            state <= DONE1;
            valid <= 1'b0;
            done  <= 1'b1;
          end else out <= out + 1'b1;
        end
        DONE1: state <= DONE2;
        DONE2: begin
          state <= IDLE;
          done  <= 1'b0;
          out   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef QPP_ADDR_EN
  localparam logic [IDX_W-1:0] KS  = IDX_W'(K_S);
  localparam logic [IDX_W-1:0] KL  = IDX_W'(K_L);
  localparam logic [IDX_W-1:0] G0S = IDX_W'((F1_S + F2_S) % K_S);
  localparam logic [IDX_W-1:0] G0L = IDX_W'((F1_L + F2_L) % K_L);
  localparam logic [IDX_W-1:0] D0S = IDX_W'((2 * F2_S) % K_S);
  localparam logic [IDX_W-1:0] D0L = IDX_W'((2 * F2_L) % K_L);
  logic [IDX_W-1:0] g, d, kk;
  logic             step;
  assign kk   = k_sel ? KL : KS;
  assign step = state == RUN && !hold && !last;
  function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W-1:0] a, b, m);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, m}) ? IDX_W'(s - {1'b0, m}) : s[IDX_W-1:0];
  endfunction
  // Second-order difference recurrence: pi(i+1) = pi(i) + g, g grows by constant d
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_int <= '0;
      g       <= '0;
      d       <= '0;
    end else if (state == IDLE && ready) begin
      out_int <= '0;
      g       <= k ? G0L : G0S;
      d       <= k ? D0L : D0S;
    end else if (step) begin
      out_int <= mod_add(out_int, g, kk);
      g       <= mod_add(g, d, kk);
    end else if (state == DONE2) out_int <= '0;
  end
`else
  assign out_int = out;
`endif
endmodule

// File: doc/qpp_ind_gen.md
QPP_IND_GEN -- requirements
Module: qpp_ind_gen

Interface
REQ-001 Parameter IDX_W, default 14: width of index outputs and internal arithmetic (sums use IDX_W+1 bits).
REQ-002 Parameter K_S, default 1056: block length when k=0.
REQ-003 Parameter K_L, default 6144: block length when k=1.
REQ-004 Parameters F1_S/F2_S, default 17/66: QPP coefficients for K_S.
REQ-005 Parameters F1_L/F2_L, default 263/480: QPP coefficients for K_L.
REQ-006 clock  in  1  single clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 k  in  1  block-size select; 1 = K_L, 0 = K_S; sampled only on block start.
REQ-009 ready  in  1  start request; sampled in IDLE only.
REQ-010 hold  in  1  stall; freezes index progression while in RUN.
REQ-011 out  out  IDX_W  sequential index i.
REQ-012 out_int  out  IDX_W  interleaved index pi(i) = (F1*i + F2*i*i) mod K.
REQ-013 valid  out  1  high when out/out_int hold a valid index pair.
REQ-014 done  out  1  block-complete flag, high for exactly two cycles.

Function
REQ-015 FSM states IDLE, RUN, DONE1, DONE2; all outputs registered.
REQ-016 IDLE: valid=0, done=0, out=0, out_int=0; ready=1 at an edge latches k into K/F1/F2 selection and enters RUN.
REQ-017 First RUN cycle presents out=0, out_int=0, valid=1 (one-cycle latency from ready sample).
REQ-018 On start, increment g SHALL load (F1+F2) mod K and step d SHALL load (2*F2) mod K.
REQ-019 RUN with hold=0 and out<K-1: out<=out+1; out_int<=(out_int+g) mod K; g<=(g+d) mod K.
REQ-020 Modular reductions SHALL be single compare-and-subtract of K; no multipliers or dividers.
REQ-021 RUN with hold=1: out, out_int, g unchanged; valid stays 1 (consumer sees same pair repeated).
REQ-022 RUN with out=K-1 and hold=0: next state DONE1, out/out_int hold final values, valid<=0.
REQ-023 RUN with out=K-1 and hold=1: remain in RUN holding K-1 pair.
REQ-024 DONE1 -> DONE2 -> IDLE unconditionally; done=1 in both; ready ignored in DONE1/DONE2.
REQ-025 Changes on k after start SHALL NOT affect the block in progress.
REQ-026 Back-to-back blocks: ready held high through DONE2 SHALL start a new block on the first IDLE edge.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, out=0, out_int=0, g=0, d=0, valid=0, done=0, regardless of state.
REQ-028 Reset asserted mid-block SHALL abandon the block; no done pulse is produced for it.
REQ-029 First edge after reset release behaves as IDLE (ready sampled normally).

Configuration
REQ-030 Macro QPP_ADDR_EN defined: out_int, g and d datapath per REQ-012/018/019.
REQ-031 QPP_ADDR_EN undefined: out_int SHALL equal out every cycle; g/d logic not synthesized; FSM, valid, done unchanged.

Verification
REQ-032 k=0, ready pulse, hold=0: out_int sequence 0, 83, 298, ... last pair out=1055/out_int=49; done high exactly 2 cycles after.
REQ-033 k=1, ready pulse: out_int 0, 743, 2446, ... last pair out=6143/out_int=217; 6144 valid cycles total; all out_int values distinct.
REQ-034 k=0, hold=1 for 3 cycles at out=5: pair (5, pi(5)) presented 4 cycles, sequence then resumes unchanged.
REQ-035 k=1, reset pulse at out=3000: outputs 0 asynchronously, valid=0, no done; next ready with k=0 yields correct K_S sequence.
REQ-036 QPP_ADDR_EN undefined, k=0: out_int==out for all 1056 cycles; done timing identical to REQ-032.
REQ-037 k toggled every cycle mid-block and ready held high: block length and sequence unaffected; next block starts immediately after DONE2.
